game_sequencer: RTL and testbench

Top-level phase controller for the flappy-bird VGA game. It owns the game state machine (IDLE, PLAY, DYING, OVER) and debounces the flap button. It derives frame-aligned tick enables for the gravity, pipe-scroll and flash datapaths from the VGA frame start, and keeps the two-digit BCD score. Everything runs on clk25M, so the per-feature clock dividers are replaced by single-cycle enables.

---
 rtl/game_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Phase controller for the flappy-bird VGA game: flap-button debounce, game FSM,
// frame-aligned gravity/pipe/flash enables and the two-digit BCD score.
module game_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned GRAVITY_DIV     = 2,
  parameter int unsigned PIPE_DIV        = 3,
  parameter int unsigned DYING_FRAMES    = 60,
  parameter int unsigned FLASH_FRAMES    = 30
) (
  input  logic       clk25M,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       btn_up_n,
  input  logic       hit_pipe,
  input  logic       out_of_bounds,
  input  logic       pipe_passed,
  output logic [1:0] state,
  output logic       flap_pulse,
  output logic       gravity_tick,
  output logic       pipe_tick,
  output logic       clear_world,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       flash,
  output logic       game_over
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FC_MAX = (DYING_FRAMES > FLASH_FRAMES) ? DYING_FRAMES : FLASH_FRAMES;
  localparam int unsigned FC_W   = $clog2(FC_MAX + 1);
  localparam int unsigned GD_W   = $clog2(GRAVITY_DIV + 1);
  localparam int unsigned PD_W   = $clog2(PIPE_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  logic [1:0]      sync_q;
  logic            btn_acc_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            press_q;

  state_t          state_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic [FC_W-1:0] entry_cnt;
  logic [GD_W-1:0] grav_cnt_q, grav_cnt_d, grav_base;
  logic [PD_W-1:0] pipe_cnt_q, pipe_cnt_d, pipe_base;
  logic            grav_tick_d, pipe_tick_d;
  logic            flap_q, grav_tick_q, pipe_tick_q, clear_q, flash_q, over_q;
  logic [3:0]      ones_q, tens_q, ones_d, tens_d;
  logic            collide, start_play, grav_en, pipe_en;

  // Accepted level starts released; a press is the accepted level falling.
  always_ff @(posedge clk25M or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      btn_acc_q <= 1'b1;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_up_n};
      press_q <= 1'b0;
      if (sync_q[1] != btn_acc_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_acc_q <= sync_q[1];
          db_cnt_q  <= '0;
          press_q   <= btn_acc_q;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign collide    = hit_pipe | out_of_bounds;
  assign start_play = (state_q == S_IDLE) && press_q;
  assign entry_cnt  = frame_start ? FC_W'(1) : '0;

  // A frame_start coinciding with a transition belongs to the state being entered.
  assign grav_en = frame_start && (start_play || state_q == S_PLAY || state_q == S_DYING);
  assign pipe_en = frame_start && (start_play || (state_q == S_PLAY && !collide));

  always_comb begin
    grav_base   = start_play ? '0 : grav_cnt_q;
    grav_tick_d = grav_en && (grav_base == GD_W'(GRAVITY_DIV - 1));
    grav_cnt_d  = start_play ? '0 : grav_cnt_q;
    if (grav_en) grav_cnt_d = grav_tick_d ? '0 : grav_base + 1'b1;

    pipe_base   = start_play ? '0 : pipe_cnt_q;
    pipe_tick_d = pipe_en && (pipe_base == PD_W'(PIPE_DIV - 1));
    pipe_cnt_d  = start_play ? '0 : pipe_cnt_q;
    if (pipe_en) pipe_cnt_d = pipe_tick_d ? '0 : pipe_base + 1'b1;

    ones_d = ones_q;
    tens_d = tens_q;
    if (state_q == S_PLAY && pipe_passed && !(ones_q == 4'd9 && tens_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 1'b1;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk25M or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      grav_cnt_q  <= '0;
      pipe_cnt_q  <= '0;
      flap_q      <= 1'b0;
      grav_tick_q <= 1'b0;
      pipe_tick_q <= 1'b0;
      clear_q     <= 1'b0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      flash_q     <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      flap_q      <= 1'b0;
      clear_q     <= 1'b0;
      grav_tick_q <= grav_tick_d;
      pipe_tick_q <= pipe_tick_d;
      grav_cnt_q  <= grav_cnt_d;
      pipe_cnt_q  <= pipe_cnt_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      case (state_q)
        S_IDLE: begin
          if (press_q) begin
            state_q     <= S_PLAY;
            flap_q      <= 1'b1;
            frame_cnt_q <= entry_cnt;
          end
        end
        S_PLAY: begin
          // Collision takes priority over a flap in the same cycle.
          if (collide) begin
            state_q     <= S_DYING;
            over_q      <= 1'b1;
            frame_cnt_q <= entry_cnt;
          end else begin
            flap_q <= press_q;
          end
        end
        S_DYING: begin
          if (frame_start) begin
            if (frame_cnt_q == FC_W'(DYING_FRAMES - 1)) begin
              state_q     <= S_OVER;
              frame_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        S_OVER: begin
          if (press_q) begin
            state_q     <= S_IDLE;
            clear_q     <= 1'b1;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            flash_q     <= 1'b0;
            over_q      <= 1'b0;
            frame_cnt_q <= '0;
          end else if (frame_start) begin
            if (frame_cnt_q == FC_W'(FLASH_FRAMES - 1)) begin
              flash_q     <= ~flash_q;
              frame_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign flap_pulse   = flap_q;
  assign gravity_tick = grav_tick_q;
  assign pipe_tick    = pipe_tick_q;
  assign clear_world  = clear_q;
  assign score_ones   = ones_q;
  assign score_tens   = tens_q;
  assign flash        = flash_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboarded bench for game_sequencer: a frame/score level reference model predicts
// every output event; a monitor compares each event the DUT presents at the negedge.
module tb_game_sequencer;

  localparam int DEB  = 4;
  localparam int GD   = 2;
  localparam int PD   = 3;
  localparam int DYF  = 5;
  localparam int FLF  = 2;
  localparam int FPER = 20;

  logic       clk25M = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       btn_up_n = 1'b1;
  logic       hit_pipe = 1'b0;
  logic       out_of_bounds = 1'b0;
  logic       pipe_passed = 1'b0;
  logic [1:0] state;
  logic       flap_pulse, gravity_tick, pipe_tick, clear_world, flash, game_over;
  logic [3:0] score_ones, score_tens;

  game_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .GRAVITY_DIV    (GD),
    .PIPE_DIV       (PD),
    .DYING_FRAMES   (DYF),
    .FLASH_FRAMES   (FLF)
  ) dut (
    .clk25M       (clk25M),
    .rst          (rst),
    .frame_start  (frame_start),
    .btn_up_n     (btn_up_n),
    .hit_pipe     (hit_pipe),
    .out_of_bounds(out_of_bounds),
    .pipe_passed  (pipe_passed),
    .state        (state),
    .flap_pulse   (flap_pulse),
    .gravity_tick (gravity_tick),
    .pipe_tick    (pipe_tick),
    .clear_world  (clear_world),
    .score_ones   (score_ones),
    .score_tens   (score_tens),
    .flash        (flash),
    .game_over    (game_over)
  );

  always #20 clk25M = ~clk25M;

  int cyc = 0;
  always @(posedge clk25M) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ev_t;
  ev_t sb[$];

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  int   n_flap = 0, n_grav = 0, n_pipe = 0, n_clear = 0;
  int   fcnt = 0;

  // Reference model state: button history, phase, frame counts, decimal score.
  int   m_s1, m_s2, m_acc, m_run;
  bit   m_press;
  int   m_phase, m_score, m_play_frames, m_dying_frames, m_over_frames;
  bit   m_flash;
  logic [15:0] m_prev;
  int   m_grav_total;

  function automatic logic [15:0] pack(logic [1:0] st, logic fl, logic gr, logic pi, logic cl,
                                       logic [3:0] on, logic [3:0] te, logic fs, logic go);
    return {st, fl, gr, pi, cl, on, te, fs, go};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_acc = 1; m_run = 0; m_press = 0;
    m_phase = 0; m_score = 0; m_play_frames = 0; m_dying_frames = 0; m_over_frames = 0;
    m_flash = 0; m_prev = '0;
  endtask

  task automatic model_step();
    bit fl = 0, gr = 0, pi = 0, cl = 0, new_press = 0;
    logic [15:0] vec;
    case (m_phase)
      0: if (m_press) begin
        m_phase = 1; fl = 1; m_play_frames = 0;
        if (frame_start) begin
          m_play_frames = 1; gr = (1 % GD == 0); pi = (1 % PD == 0);
        end
      end
      1: begin
        if (pipe_passed && m_score < 99) m_score++;
        if (frame_start) m_play_frames++;
        if (hit_pipe || out_of_bounds) begin
          m_phase = 2;
          m_dying_frames = frame_start ? 1 : 0;
          if (frame_start) gr = (m_play_frames % GD == 0);
        end else begin
          fl = m_press;
          if (frame_start) begin
            gr = (m_play_frames % GD == 0); pi = (m_play_frames % PD == 0);
          end
        end
      end
      2: if (frame_start) begin
        m_play_frames++; gr = (m_play_frames % GD == 0);
        m_dying_frames++;
        if (m_dying_frames == DYF) begin m_phase = 3; m_over_frames = 0; end
      end
      default: if (m_press) begin
        m_phase = 0; cl = 1; m_score = 0; m_flash = 0;
      end else if (frame_start) begin
        m_over_frames++; m_flash = ((m_over_frames / FLF) % 2) == 1;
      end
    endcase
    if (m_s2 != m_acc) begin
      m_run++;
      if (m_run == DEB) begin m_acc = m_s2; m_run = 0; new_press = (m_acc == 0); end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1; m_s1 = int'(btn_up_n); m_press = new_press;
    if (gr) m_grav_total++;
    vec = pack(2'(m_phase), fl, gr, pi, cl, 4'(m_score % 10), 4'(m_score / 10), m_flash, m_phase >= 2);
    if (vec != m_prev || fl || gr || pi || cl) sb.push_back('{cyc + 1, vec});
    m_prev = vec;
  endtask

  task automatic monitor();
    logic [15:0] prev, v;
    ev_t e;
    bit done;
    prev = '0;
    forever begin
      @(negedge clk25M);
      if (!mon_en) begin
        prev = '0;
      end else begin
        v = pack(state, flap_pulse, gravity_tick, pipe_tick, clear_world,
                 score_ones, score_tens, flash, game_over);
        n_flap += int'(flap_pulse); n_grav += int'(gravity_tick);
        n_pipe += int'(pipe_tick); n_clear += int'(clear_world);
        if (v != prev || (|v[13:10])) begin
          done = 0;
          while (!done) begin
            total++;
            if (sb.size() == 0) begin
              bad++; done = 1;
              $display("FAIL sb_unexpected cyc=%0d got=%h want=none", cyc, v);
            end else if (sb[0].cyc < cyc) begin
              e = sb.pop_front(); bad++;
              $display("FAIL sb_missed cyc=%0d got=none want=%h", e.cyc, e.v);
            end else if (sb[0].cyc > cyc) begin
              bad++; done = 1;
              $display("FAIL sb_extra cyc=%0d got=%h want=none", cyc, v);
            end else begin
              e = sb.pop_front(); done = 1;
              if (e.v != v) begin
                bad++;
                $display("FAIL sb_value cyc=%0d got=%h want=%h", cyc, v, e.v);
              end
            end
          end
        end
        prev = v;
      end
    end
  endtask

  task automatic step(input logic b, input logic h, input logic o, input logic p);
    frame_start = (fcnt == 0);
    fcnt = (fcnt + 1) % FPER;
    btn_up_n = b; hit_pipe = h; out_of_bounds = o; pipe_passed = p;
    model_step();
    @(posedge clk25M);
    #1;
  endtask

  task automatic steps(input int n, input logic b);
    for (int i = 0; i < n; i++) step(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n, input logic b);
    int seen = 0;
    while (seen < n) begin
      if (fcnt == 0) seen++;
      step(b, 1'b0, 1'b0, 1'b0);
    end
    steps(2, b);
  endtask

  task automatic press();
    steps(10, 1'b0);
    steps(6, 1'b1);
  endtask

  task automatic score_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      steps(2, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, g0, p0, c0, mg0;
    int hold;
    logic bv;
    model_reset();
    m_grav_total = 0;
    fork
      monitor();
    join_none

    #2 rst = 1'b0;
    #1;
    $display("txn reset");
    chk("rst_state", int'(state), 0);
    chk("rst_ones", int'(score_ones), 0);
    chk("rst_tens", int'(score_tens), 0);
    chk("rst_flash", int'(flash), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_pulses", int'({flap_pulse, gravity_tick, pipe_tick, clear_world}), 0);
    @(posedge clk25M);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    $display("txn bouncy press");
    f0 = n_flap;
    steps(2, 1'b0);
    steps(3, 1'b1);
    steps(10, 1'b0);
    steps(6, 1'b1);
    chk("bounce_state", int'(state), 1);
    chk("bounce_flaps", n_flap - f0, 1);

    $display("txn tick cadence 12 frames");
    while (fcnt != 5) step(1'b1, 1'b0, 1'b0, 1'b0);
    g0 = n_grav; p0 = n_pipe;
    frames(12, 1'b1);
    chk("cadence_grav", n_grav - g0, 6);
    chk("cadence_pipe", n_pipe - p0, 4);

    $display("txn scoring");
    score_pulses(9);
    chk("score9_ones", int'(score_ones), 9);
    chk("score9_tens", int'(score_tens), 0);
    score_pulses(1);
    chk("score10_ones", int'(score_ones), 0);
    chk("score10_tens", int'(score_tens), 1);
    score_pulses(90);
    chk("score_sat_ones", int'(score_ones), 9);
    chk("score_sat_tens", int'(score_tens), 9);

    $display("txn collision with press");
    while (fcnt != 5) step(1'b1, 1'b0, 1'b0, 1'b0);
    hold = 0;
    while (!m_press && hold < 20) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      hold++;
    end
    chk("press_bound", int'(m_press), 1);
    f0 = n_flap;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    steps(2, 1'b0);
    chk("collide_state", int'(state), 2);
    chk("collide_no_flap", n_flap - f0, 0);
    chk("collide_game_over", int'(game_over), 1);

    $display("txn dying");
    g0 = n_grav; p0 = n_pipe; mg0 = m_grav_total;
    frames(4, 1'b1);
    chk("dying_4_frames", int'(state), 2);
    frames(1, 1'b1);
    chk("dying_5_frames", int'(state), 3);
    chk("dying_pipe", n_pipe - p0, 0);
    chk("dying_grav", n_grav - g0, m_grav_total - mg0);

    $display("txn over flashing");
    frames(7, 1'b1);
    chk("over_flash", int'(flash), 1);
    c0 = n_clear;
    press();
    chk("restart_clear", n_clear - c0, 1);
    chk("restart_state", int'(state), 0);
    chk("restart_score", int'({score_tens, score_ones}), 0);
    chk("restart_flash", int'(flash), 0);
    chk("restart_game_over", int'(game_over), 0);

    $display("txn async reset mid play");
    press();
    score_pulses(37);
    chk("pre_reset_score", int'({score_tens, score_ones}), 8'h37);
    mon_en = 1'b0;
    #5 rst = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_score", int'({score_tens, score_ones}), 0);
    chk("async_game_over", int'(game_over), 0);
    sb.delete();
    model_reset();
    @(posedge clk25M);
    #1;
    @(posedge clk25M);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    g0 = n_grav; p0 = n_pipe; c0 = n_clear;
    frames(4, 1'b1);
    chk("post_reset_grav", n_grav - g0, 0);
    chk("post_reset_pipe", n_pipe - p0, 0);
    chk("post_reset_clear", n_clear - c0, 0);
    chk("post_reset_state", int'(state), 0);

    $display("txn random play");
    bv = 1'b1;
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        bv = ~bv;
        hold = (bv == 1'b1) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12));
      end
      hold--;
      step(bv, ($urandom_range(0, 299) == 0), ($urandom_range(0, 399) == 0),
           ($urandom_range(0, 14) == 0));
    end
    steps(3, 1'b1);
    @(negedge clk25M);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
